// File: rtl/seq_bam_mult.sv
// Sequential broken-array multiplier: one partial-product row per cycle, run-time h/v breaks.
// Define SEQ_BAM_ERR_EN to also accumulate the omitted terms so that err = exact product - out.
module seq_bam_mult #(
  parameter int N = 8,
  localparam int HW = $clog2(N + 1),
  localparam int VW = $clog2(2 * N + 1),
  localparam int PW = 2 * N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [HW-1:0] h,
  input  logic [VW-1:0] v,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out,
  output logic [PW-1:0] err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [HW-1:0] N_HW = HW'(N);

  state_t        state, next_state;
  logic [N-1:0]  a_q, b_q;
  logic [HW-1:0] h_q, row_q;
  logic [VW-1:0] v_q;
  logic [PW-1:0] acc_q;

  logic [HW-1:0] h_clamp, start_row;
  logic          accept, last_row, bj;
  logic [N-1:0]  mask;
  logic [PW-1:0] kept_add;

  // Bit i of row j survives when the row is not horizontally broken and weight i+j >= v.
  function automatic logic [N-1:0] keep_mask(input logic [HW-1:0] row,
                                             input logic [HW-1:0] hc,
                                             input logic [VW-1:0] vb);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++)
      m[i] = (row >= hc) && ((i + int'(row)) >= int'(vb));
    return m;
  endfunction

  assign h_clamp = (h > N_HW) ? N_HW : h;
`ifdef SEQ_BAM_ERR_EN
  assign start_row = '0;
`else
  assign start_row = h_clamp;
`endif

  assign accept   = (state == S_IDLE) && in_valid && in_ready;
  assign last_row = (state == S_RUN) && (row_q == N_HW - HW'(1));
  assign bj       = |(b_q & (N'(1) << row_q));
  assign mask     = keep_mask(row_q, h_q, v_q);
  assign kept_add = bj ? (PW'(a_q & mask) << row_q) : '0;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept) next_state = (start_row == N_HW) ? S_DONE : S_RUN;
      S_RUN:  if (last_row) next_state = S_DONE;
      S_DONE: if (out_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state == S_IDLE);
      out_valid <= (next_state == S_DONE);
    end
  end

  // Operand capture: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
      h_q <= h_clamp;
      v_q <= v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      acc_q <= '0;
      out   <= '0;
    end else if (accept) begin
      row_q <= start_row;
      acc_q <= '0;
      if (start_row == N_HW) out <= '0;
    end else if (state == S_RUN) begin
      row_q <= row_q + HW'(1);
      acc_q <= acc_q + kept_add;
      if (last_row) out <= acc_q + kept_add;
    end
  end

`ifdef SEQ_BAM_ERR_EN
  logic [PW-1:0] err_acc_q, omit_add;

  assign omit_add = bj ? (PW'(a_q & ~mask) << row_q) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_acc_q <= '0;
      err       <= '0;
    end else if (accept) begin
      err_acc_q <= '0;
    end else if (state == S_RUN) begin
      err_acc_q <= err_acc_q + omit_add;
      if (last_row) err <= err_acc_q + omit_add;
    end
  end
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_seq_bam_mult.sv
// Randomized self-checking bench for seq_bam_mult against a direct sum-of-kept-terms model.
module tb_seq_bam_mult;
  localparam int N  = 8;
  localparam int HW = $clog2(N + 1);
  localparam int VW = $clog2(2 * N + 1);
  localparam int PW = 2 * N;
`ifdef SEQ_BAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic [HW-1:0] h = '0;
  logic [VW-1:0] v = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out;
  logic [PW-1:0] err;

  int n_chk = 0;
  int n_err = 0;

  seq_bam_mult #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .h(h), .v(v),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: sum every kept partial-product bit directly from the definition.
  function automatic logic [PW-1:0] ref_out(input logic [N-1:0] fa, input logic [N-1:0] fb,
                                            input int fh, input int fv);
    longint s;
    int hc;
    s  = 0;
    hc = (fh > N) ? N : fh;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        if (fa[i] && fb[j] && j >= hc && (i + j) >= fv)
          s += longint'(1) << (i + j);
    return PW'(s);
  endfunction

  function automatic logic [PW-1:0] ref_err(input logic [N-1:0] fa, input logic [N-1:0] fb,
                                            input int fh, input int fv);
    logic [PW-1:0] exact;
    exact = PW'(fa) * PW'(fb);
    return ERR_EN ? (exact - ref_out(fa, fb, fh, fv)) : '0;
  endfunction

  function automatic int ref_lat(input int fh);
    return ERR_EN ? N : (N - ((fh > N) ? N : fh));
  endfunction

  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check_val({tag, "_rdy"}, 64'(in_ready), 64'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 4 * N) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [N-1:0] op_a, input logic [N-1:0] op_b,
                        input int op_h, input int op_v, input int hold, input string tag);
    logic [PW-1:0] exp_out, exp_err;
    int lat;
    exp_out = ref_out(op_a, op_b, op_h, op_v);
    exp_err = ref_err(op_a, op_b, op_h, op_v);
    a = op_a; b = op_b; h = HW'(op_h); v = VW'(op_v);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    wait_ready(tag);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = N'($urandom); b = N'($urandom); h = HW'($urandom); v = VW'($urandom);
    wait_valid(lat);
    check_val({tag, "_lat"}, 64'(lat), 64'(ref_lat(op_h)));
    check_val({tag, "_out"}, 64'(out), 64'(exp_out));
    check_val({tag, "_err"}, 64'(err), 64'(exp_err));
    check_val({tag, "_busy"}, 64'(in_ready), 64'd0);
    repeat (hold) begin
      @(posedge clk); #1;
      check_val({tag, "_bp_vld"}, 64'(out_valid), 64'd1);
      check_val({tag, "_bp_out"}, 64'(out), 64'(exp_out));
      check_val({tag, "_bp_rdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val({tag, "_idle_vld"}, 64'(out_valid), 64'd0);
    check_val({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [N-1:0] ra, rb;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_vld", 64'(out_valid), 64'd0);
    check_val("rst_rdy", 64'(in_ready), 64'd0);
    check_val("rst_out", 64'(out), 64'd0);
    check_val("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("rst_rel_rdy", 64'(in_ready), 64'd1);

    run_op(8'd255, 8'd255, 2, 9, 0, "brk");
    run_op(8'd200, 8'd123, 0, 0, 0, "exact");
    ra = N'($urandom); rb = N'($urandom);
    run_op(ra, rb, 8, int'($urandom_range(0, 31)), 0, "hfull");
    ra = N'($urandom); rb = N'($urandom);
    run_op(ra, rb, 15, int'($urandom_range(0, 31)), 1, "hclamp");
    run_op(8'd3, 8'd5, 0, 0, 5, "bp");

    // Reset while row 3 is in flight
    a = 8'd200; b = 8'd123; h = '0; v = '0;
    in_valid = 1'b1; out_ready = 1'b1;
    wait_ready("mid");
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("mid_rst_vld", 64'(out_valid), 64'd0);
    check_val("mid_rst_out", 64'(out), 64'd0);
    check_val("mid_rst_rdy", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check_val("mid_rel_rdy", 64'(in_ready), 64'd1);
    repeat (N) begin
      @(posedge clk); #1;
      check_val("mid_no_vld", 64'(out_valid), 64'd0);
    end
    run_op(8'd7, 8'd9, 0, 0, 0, "after_rst");

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    a = 8'd255; b = 8'd1; h = HW'(0); v = VW'(4);
    in_valid = 1'b1;
    wait_ready("b2b1");
    @(posedge clk); #1;
    a = 8'd1; b = 8'd255; h = HW'(4); v = VW'(0);
    wait_valid(lat);
    check_val("b2b1_lat", 64'(lat), 64'(ref_lat(0)));
    check_val("b2b1_out", 64'(out), 64'(ref_out(8'd255, 8'd1, 0, 4)));
    check_val("b2b1_err", 64'(err), 64'(ref_err(8'd255, 8'd1, 0, 4)));
    @(posedge clk); #1;
    check_val("b2b1_idle_vld", 64'(out_valid), 64'd0);
    check_val("b2b1_idle_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check_val("b2b2_busy", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    wait_valid(lat);
    check_val("b2b2_lat", 64'(lat), 64'(ref_lat(4)));
    check_val("b2b2_out", 64'(out), 64'(ref_out(8'd1, 8'd255, 4, 0)));
    check_val("b2b2_err", 64'(err), 64'(ref_err(8'd1, 8'd255, 4, 0)));
    @(posedge clk); #1;
    check_val("b2b2_idle_rdy", 64'(in_ready), 64'd1);
    out_ready = 1'b0;

    for (int k = 0; k < 25; k++) begin
      ra = N'($urandom); rb = N'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 2)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
